// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer: FSM states, cause encoding and
// the counter-width function.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        StHold,
        StWaitLock,
        StRelease,
        StRun
    } state_e;

    localparam int unsigned CAUSE_EXT  = 0;
    localparam int unsigned CAUSE_SOFT = 1;
    localparam int unsigned CAUSE_LOCK = 2;

    localparam logic [2:0] CauseExtOh  = 3'(1 << CAUSE_EXT);
    localparam logic [2:0] CauseSoftOh = 3'(1 << CAUSE_SOFT);
    localparam logic [2:0] CauseLockOh = 3'(1 << CAUSE_LOCK);

    // The counter must reach both the hold length and the last release offset.
    function automatic int unsigned cnt_width(input int unsigned cycles,
                                              input int unsigned num_outputs,
                                              input int unsigned stage_gap);
        int unsigned span;
        span = stage_gap * (num_outputs - 1);
        if (cycles > span) begin
            span = cycles;
        end
        return $clog2(span + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Bus between the reset sequencer and its environment: lock/request inputs and the
// sequenced reset outputs with status.
interface reset_sequencer_if #(
    parameter int unsigned NUM_OUTPUTS = 3
);
    logic                   locked;
    logic                   soft_reset_req;
    logic [NUM_OUTPUTS-1:0] reset_o;
    logic                   ready;
    logic [2:0]             reset_cause;

    modport master (
        output locked,
        output soft_reset_req,
        input  reset_o,
        input  ready,
        input  reset_cause
    );

    modport slave (
        input  locked,
        input  soft_reset_req,
        output reset_o,
        output ready,
        output reset_cause
    );
endinterface

// File: rtl/reset_sequencer_reset_sync.sv
// Two-flop synchroniser with asynchronous load. ResetValue=1, d_i=0 gives an
// async-assert/sync-release reset; ResetValue=0 gives a plain level synchroniser.
module reset_sync #(
    parameter bit ResetValue = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {2{ResetValue}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-on/runtime reset sequencer: hold, wait for lock, staged release, run.
// Optional cause register enabled by defining RESET_SEQ_CAUSE_EN.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned CYCLES      = 20,
    parameter int unsigned NUM_OUTPUTS = 3,
    parameter int unsigned STAGE_GAP   = 4
) (
    input  logic              clk,
    input  logic              reset,
    reset_sequencer_if.slave  bus
);

    localparam int unsigned CntW     = cnt_width(CYCLES, NUM_OUTPUTS, STAGE_GAP);
    localparam logic [CntW-1:0] HoldLast = CntW'(CYCLES - 1);
    localparam logic [CntW-1:0] RelLast  = CntW'(STAGE_GAP * (NUM_OUTPUTS - 1));
    localparam state_e          AfterHold = (NUM_OUTPUTS == 1) ? StRun : StRelease;

    logic rst_s;
    logic locked_s;

    reset_sync #(
        .ResetValue(1'b1)
    ) u_rst_sync (
        .clk_i(clk),
        .rst_i(reset),
        .d_i  (1'b0),
        .q_o  (rst_s)
    );

    reset_sync #(
        .ResetValue(1'b0)
    ) u_lock_sync (
        .clk_i(clk),
        .rst_i(reset),
        .d_i  (bus.locked),
        .q_o  (locked_s)
    );

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [NUM_OUTPUTS-1:0] reset_o_q, reset_o_d;
    logic                   hold_done;
    logic                   start_release;
    logic                   lock_loss;
    logic                   soft_hit;

    assign cnt_inc   = cnt_q + CntW'(1);
    assign hold_done = (cnt_q == HoldLast);
    assign lock_loss = !locked_s && (state_q == StRelease || state_q == StRun);
    assign soft_hit  = bus.soft_reset_req;
    assign start_release = locked_s &&
                           ((state_q == StHold && hold_done) || state_q == StWaitLock);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        reset_o_d = reset_o_q;

        unique case (state_q)
            StHold: begin
                if (!hold_done) begin
                    cnt_d = cnt_inc;
                end else begin
                    cnt_d = '0;
                    if (!locked_s) begin
                        state_d = StWaitLock;
                    end
                end
            end
            StWaitLock: begin
                cnt_d = '0;
            end
            StRelease: begin
                // cnt counts edges since reset_o[0] was released.
                cnt_d = cnt_inc;
                for (int unsigned i = 1; i < NUM_OUTPUTS; i++) begin
                    if (cnt_inc == CntW'(STAGE_GAP * i)) begin
                        reset_o_d[i] = 1'b0;
                    end
                end
                if (cnt_inc == RelLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                reset_o_d = '0;
            end
            default: begin
                state_d = StHold;
            end
        endcase

        if (start_release) begin
            reset_o_d[0] = 1'b0;
            state_d      = AfterHold;
        end

        // Lock loss and soft request both restart the hold from scratch.
        if (lock_loss || soft_hit) begin
            state_d   = StHold;
            cnt_d     = '0;
            reset_o_d = '1;
        end
    end

    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            state_q   <= StHold;
            cnt_q     <= '0;
            reset_o_q <= '1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            reset_o_q <= reset_o_d;
        end
    end

    assign bus.reset_o = reset_o_q;
    assign bus.ready   = (state_q == StRun);

`ifdef RESET_SEQ_CAUSE_EN
    logic [2:0] cause_q, cause_d;

    // Lock loss outranks a same-cycle soft request.
    always_comb begin
        cause_d = cause_q;
        if (lock_loss) begin
            cause_d = CauseLockOh;
        end else if (soft_hit) begin
            cause_d = CauseSoftOh;
        end
    end

    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            cause_q <= CauseExtOh;
        end else begin
            cause_q <= cause_d;
        end
    end

    assign bus.reset_cause = cause_q;
`else
    assign bus.reset_cause = 3'b000;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues expected output changes with
// their edge numbers, a negedge monitor pops and compares on every output change.
module tb_reset_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    reset_sequencer_if #(.NUM_OUTPUTS(3)) bus ();

    reset_sequencer #(
        .CYCLES     (20),
        .NUM_OUTPUTS(3),
        .STAGE_GAP  (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

`ifdef RESET_SEQ_CAUSE_EN
    localparam logic [2:0] C_EXT  = 3'b001;
    localparam logic [2:0] C_SOFT = 3'b010;
    localparam logic [2:0] C_LOCK = 3'b100;
`else
    localparam logic [2:0] C_EXT  = 3'b000;
    localparam logic [2:0] C_SOFT = 3'b000;
    localparam logic [2:0] C_LOCK = 3'b000;
`endif

    typedef struct {
        int         at_edge;
        logic [6:0] val;
    } ev_t;

    ev_t  exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_n   = 0;
    bit   mon_en   = 1'b0;
    logic [6:0] prev;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic expect_ev(input int at, input logic [2:0] r, input logic rdy,
                             input logic [2:0] c);
        ev_t e;
        e.at_edge = at;
        e.val     = {r, rdy, c};
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [6:0] want);
        logic [6:0] got;
        got = {bus.reset_o, bus.ready, bus.reset_cause};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got reset_o/ready/cause=%b want=%b", name, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every change of the output bundle must match the next queued event.
    always @(negedge clk) begin
        logic [6:0] cur;
        ev_t        e;
        cur = {bus.reset_o, bus.ready, bus.reset_cause};
        if (!mon_en) begin
            prev = cur;
        end else if (cur !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change: edge=%0d got=%b", edge_n, cur);
            end else begin
                e = exp_q.pop_front();
                if (e.at_edge != edge_n || e.val !== cur) begin
                    failures++;
                    $display("FAIL event: got edge=%0d val=%b want edge=%0d val=%b",
                             edge_n, cur, e.at_edge, e.val);
                end
            end
            prev = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
        $fatal(1);
    end

    initial begin
        int t0;
        int t;
        int f;
        reset              = 1'b1;
        bus.locked         = 1'b1;
        bus.soft_reset_req = 1'b0;

        // Power-up release: bits fall at 22, 26, 30 edges after reset drops.
        step(3);
        check_now("reset_state", {3'b111, 1'b0, C_EXT});
        mon_en = 1'b1;
        step(1);
        reset = 1'b0;
        t0 = edge_n;
        expect_ev(t0 + 22, 3'b110, 1'b0, C_EXT);
        expect_ev(t0 + 26, 3'b100, 1'b0, C_EXT);
        expect_ev(t0 + 30, 3'b000, 1'b1, C_EXT);
        step(35);
        check_now("run_state", {3'b000, 1'b1, C_EXT});

        // Soft request in RUN sampled at edge t.
        t = edge_n + 1;
        expect_ev(t,      3'b111, 1'b0, C_SOFT);
        expect_ev(t + 20, 3'b110, 1'b0, C_SOFT);
        expect_ev(t + 24, 3'b100, 1'b0, C_SOFT);
        expect_ev(t + 28, 3'b000, 1'b1, C_SOFT);
        bus.soft_reset_req = 1'b1;
        step(1);
        bus.soft_reset_req = 1'b0;
        step(32);

        // Lock loss in RUN, relock after the hold has expired.
        t = edge_n;
        expect_ev(t + 3, 3'b111, 1'b0, C_LOCK);
        bus.locked = 1'b0;
        step(40);
        f = edge_n;
        expect_ev(f + 3,  3'b110, 1'b0, C_LOCK);
        expect_ev(f + 7,  3'b100, 1'b0, C_LOCK);
        expect_ev(f + 11, 3'b000, 1'b1, C_LOCK);
        bus.locked = 1'b1;
        step(15);

        // Soft request on the same edge the lock loss takes effect: lock wins.
        t = edge_n;
        expect_ev(t + 3, 3'b111, 1'b0, C_LOCK);
        bus.locked = 1'b0;
        step(2);
        bus.soft_reset_req = 1'b1;
        step(1);
        bus.soft_reset_req = 1'b0;
        step(37);
        f = edge_n;
        expect_ev(f + 3,  3'b110, 1'b0, C_LOCK);
        expect_ev(f + 7,  3'b100, 1'b0, C_LOCK);
        expect_ev(f + 11, 3'b000, 1'b1, C_LOCK);
        bus.locked = 1'b1;
        step(15);

        // External reset between the bit 0 and bit 1 releases.
        t = edge_n + 1;
        expect_ev(t,      3'b111, 1'b0, C_SOFT);
        expect_ev(t + 20, 3'b110, 1'b0, C_SOFT);
        bus.soft_reset_req = 1'b1;
        step(1);
        bus.soft_reset_req = 1'b0;
        step(21);
        expect_ev(edge_n, 3'b111, 1'b0, C_EXT);
        reset = 1'b1;
        #1;
        check_now("async_clear", {3'b111, 1'b0, C_EXT});
        step(3);
        reset = 1'b0;
        t0 = edge_n;
        expect_ev(t0 + 22, 3'b110, 1'b0, C_EXT);
        expect_ev(t0 + 26, 3'b100, 1'b0, C_EXT);
        expect_ev(t0 + 30, 3'b000, 1'b1, C_EXT);
        step(35);

        // Reset with lock absent: hold, wait for lock, then release after sync delay.
        expect_ev(edge_n, 3'b111, 1'b0, C_EXT);
        reset      = 1'b1;
        bus.locked = 1'b0;
        step(3);
        reset = 1'b0;
        t0 = edge_n;
        expect_ev(t0 + 53, 3'b110, 1'b0, C_EXT);
        expect_ev(t0 + 57, 3'b100, 1'b0, C_EXT);
        expect_ev(t0 + 61, 3'b000, 1'b1, C_EXT);
        step(50);
        check_now("wait_lock_hold", {3'b111, 1'b0, C_EXT});
        bus.locked = 1'b1;
        step(15);
        check_now("final_run", {3'b000, 1'b1, C_EXT});

        step(2);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_events: got %0d left want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
